wb_sram_slave: RTL and testbench

Wishbone classic responder wrapping an on-chip word-organised SRAM with byte-lane writes. It serves the data-side load/store master, which holds stb/cyc high until the core consumes the ack. It decodes one address window, inserts programmable wait states, and returns exactly one registered ack per access.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_sram_slave_if.sv | 27 ++
 rtl/wb_sram_bytewrite.sv | 35 +++
 rtl/wb_sram_slave.sv | 147 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding, bus widths and
// the value returned for reads that fall outside the decoded window.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   localparam logic [WB_DATA_W-1:0] WB_MISS_DATA = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RECOVER = 2'd3
   } wb_slv_state_t;

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle between the load/store master and the SRAM slave.
interface wb_sram_slave_if;
   import wb_pkg::*;

   // Handshake: a request is cyc & stb. The slave answers each accepted
   // request with exactly one ack cycle; the master keeps cyc/stb and the
   // request attributes stable until it has seen that ack.
   logic                 i_wb_cyc;
   logic                 i_wb_stb;
   logic                 i_wb_we;
   logic [WB_SEL_W-1:0]  i_wb_sel;
   logic [31:0]          i_wb_address;
   logic [WB_DATA_W-1:0] i_wb_data;
   logic [WB_DATA_W-1:0] o_wb_data;
   logic                 o_wb_ack;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_address, i_wb_data,
      input  o_wb_data, o_wb_ack
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_address, i_wb_data,
      output o_wb_data, o_wb_ack
   );

endinterface

// File: rtl/wb_sram_bytewrite.sv
// Single-port word SRAM with per-byte write enables and a registered read
// port, written in the shape synthesis maps onto block RAM.
module wb_sram_bytewrite
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic                           we,
   input  logic [WB_SEL_W-1:0]            sel,
   input  logic [$clog2(DEPTH_WORDS)-1:0] index,
   input  logic [WB_DATA_W-1:0]           wdata,
   output logic [WB_DATA_W-1:0]           rdata
);

   logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];
   logic [WB_DATA_W-1:0] rdata_q;

   // A write leaves the read register untouched so it keeps the last read word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int n = 0; n < WB_SEL_W; n++) begin
               if (sel[n]) mem[index][8*n +: 8] <= wdata[8*n +: 8];
            end
         end else begin
            rdata_q <= mem[index];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder for one address window backed by an on-chip SRAM,
// with programmable wait states and a single registered ack per access.
module wb_sram_slave
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic           clk,
   input  logic           rst,
   wb_sram_slave_if.slave bus,
   output wb_slv_state_t  o_state
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
   localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic                 req;
   logic [29:0]          word_off;
   logic                 hit_live;
   logic [IDX_W-1:0]     idx_live;
   logic                 unused_addr_lsb;

   wb_slv_state_t        state_q,   state_d;
   logic [3:0]           cnt_q,     cnt_d;
   logic                 ack_q,     ack_d;
   logic                 rd_zero_q, rd_zero_d;
   logic                 we_q,      we_d;
   logic [WB_SEL_W-1:0]  sel_q,     sel_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic                 hit_q,     hit_d;
   logic [WB_DATA_W-1:0] wdata_q,   wdata_d;

   logic                 in_idle;
   logic                 op_we;
   logic                 op_hit;
   logic [WB_SEL_W-1:0]  op_sel;
   logic [IDX_W-1:0]     op_idx;
   logic [WB_DATA_W-1:0] op_wdata;
   logic                 ram_en;
   logic [WB_DATA_W-1:0] ram_rdata;

   assign req             = bus.i_wb_cyc & bus.i_wb_stb;
   assign word_off        = bus.i_wb_address[31:2] - BASE_WORD;
   assign hit_live        = word_off < DEPTH_W30;
   assign idx_live        = word_off[IDX_W-1:0];
   assign unused_addr_lsb = ^bus.i_wb_address[1:0];

   // With no wait states the SRAM is driven straight from the bus in IDLE,
   // so the access lands on the same edge that enters ACK.
   assign in_idle  = (state_q == IDLE);
   assign op_we    = in_idle ? bus.i_wb_we   : we_q;
   assign op_hit   = in_idle ? hit_live      : hit_q;
   assign op_sel   = in_idle ? bus.i_wb_sel  : sel_q;
   assign op_idx   = in_idle ? idx_live      : idx_q;
   assign op_wdata = in_idle ? bus.i_wb_data : wdata_q;
   assign ram_en   = ack_d & op_hit;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      rd_zero_d = rd_zero_q;
      we_d      = we_q;
      sel_d     = sel_q;
      idx_d     = idx_q;
      hit_d     = hit_q;
      wdata_d   = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = bus.i_wb_we;
               sel_d   = bus.i_wb_sel;
               idx_d   = idx_live;
               hit_d   = hit_live;
               wdata_d = bus.i_wb_data;
               if (WAIT_STATES == 0) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LAST;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK:     state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A miss read forces zero on the data output until the next read.
      if (ack_d && !op_we) rd_zero_d = !op_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         ack_q     <= 1'b0;
         rd_zero_q <= 1'b1;
         we_q      <= 1'b0;
         sel_q     <= '0;
         idx_q     <= '0;
         hit_q     <= 1'b0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         rd_zero_q <= rd_zero_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         idx_q     <= idx_d;
         hit_q     <= hit_d;
         wdata_q   <= wdata_d;
      end
   end

   wb_sram_bytewrite #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (op_we),
      .sel  (op_sel),
      .index(op_idx),
      .wdata(op_wdata),
      .rdata(ram_rdata)
   );

   assign bus.o_wb_ack  = ack_q;
   assign bus.o_wb_data = rd_zero_q ? WB_MISS_DATA : ram_rdata;
   assign o_state       = state_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized bench for wb_sram_slave: two instances (0 and 3 wait states)
// checked cycle by cycle against a transaction-level memory model.
module tb_wb_sram_slave;
   import wb_pkg::*;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          MAXC  = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int checks   = 0;
   int failures = 0;

   // Reference model: memory image, last value seen on the data bus, and
   // the cycles at which an ack is owed together with what it must carry.
   logic [31:0] mdl_mem [2][DEPTH];
   logic [31:0] last_rd [2];
   bit          exp_ack [2][MAXC];
   bit          exp_rd  [2][MAXC];
   logic [31:0] exp_dat [2][MAXC];

   logic        drv_cyc   [2];
   logic        drv_stb   [2];
   logic        drv_we    [2];
   logic [3:0]  drv_sel   [2];
   logic [31:0] drv_addr  [2];
   logic [31:0] drv_wdata [2];
   logic        mon_ack   [2];
   logic [31:0] mon_data  [2];
   wb_slv_state_t st0, st3;

   wb_sram_slave_if bus0 ();
   wb_sram_slave_if bus3 ();

   assign bus0.i_wb_cyc     = drv_cyc[0];
   assign bus0.i_wb_stb     = drv_stb[0];
   assign bus0.i_wb_we      = drv_we[0];
   assign bus0.i_wb_sel     = drv_sel[0];
   assign bus0.i_wb_address = drv_addr[0];
   assign bus0.i_wb_data    = drv_wdata[0];
   assign bus3.i_wb_cyc     = drv_cyc[1];
   assign bus3.i_wb_stb     = drv_stb[1];
   assign bus3.i_wb_we      = drv_we[1];
   assign bus3.i_wb_sel     = drv_sel[1];
   assign bus3.i_wb_address = drv_addr[1];
   assign bus3.i_wb_data    = drv_wdata[1];
   assign mon_ack[0]  = bus0.o_wb_ack;
   assign mon_data[0] = bus0.o_wb_data;
   assign mon_ack[1]  = bus3.o_wb_ack;
   assign mon_data[1] = bus3.o_wb_data;

   wb_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .o_state(st0));
   wb_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3), .o_state(st3));

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit in_win(input logic [31:0] a);
      longint la, lb;
      la = longint'(a);
      lb = longint'(BASE);
      return (la >= lb) && (la < lb + longint'(DEPTH * 4));
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic mark(input int d, input int c, input bit is_rd, input logic [31:0] v);
      if (c < MAXC) begin
         exp_ack[d][c] = 1'b1;
         exp_rd[d][c]  = is_rd;
         exp_dat[d][c] = v;
      end
   endtask

   // Compare process: ack must appear exactly on owed cycles, data must
   // hold the last read value (zero after reset).
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit e;
         e = 1'b0;
         if (cyc_n < MAXC && !rst) e = exp_ack[d][cyc_n];
         if (e && exp_rd[d][cyc_n]) last_rd[d] = exp_dat[d][cyc_n];
         chk($sformatf("ack%0d_c%0d", d, cyc_n), {31'd0, mon_ack[d]}, {31'd0, e});
         chk($sformatf("data%0d_c%0d", d, cyc_n), mon_data[d], last_rd[d]);
      end
   end

   task automatic clear_bus(input int d);
      drv_cyc[d] = 1'b0;
      drv_stb[d] = 1'b0;
      drv_we[d]  = 1'($urandom_range(0, 1));
      drv_sel[d] = 4'($urandom_range(0, 15));
   endtask

   // One access; drop_at > 0 releases the request that many cycles after it
   // was presented (inside the wait window), which must abort it.
   task automatic access(input int d, input bit we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int drop_at, output logic [31:0] rd_obs);
      int n0, ackc, idx;
      bit hit;
      @(posedge clk); #1;
      drv_cyc[d] = 1'b1; drv_stb[d] = 1'b1; drv_we[d] = we;
      drv_sel[d] = sel;  drv_addr[d] = addr; drv_wdata[d] = wdata;
      n0  = cyc_n;
      hit = in_win(addr);
      idx = hit ? word_of(addr) : 0;
      rd_obs = 32'h0;
      if (drop_at > 0) begin
         while (cyc_n < n0 + drop_at) begin @(posedge clk); #1; end
         clear_bus(d);
         @(posedge clk); #1;
      end else begin
         ackc = n0 + 1 + ws_of(d);
         if (we) begin
            if (hit)
               for (int n = 0; n < 4; n++)
                  if (sel[n]) mdl_mem[d][idx][8*n +: 8] = wdata[8*n +: 8];
            mark(d, ackc, 1'b0, 32'h0);
         end else begin
            mark(d, ackc, 1'b1, hit ? mdl_mem[d][idx] : 32'h0);
         end
         @(posedge clk); #1;
         if (ws_of(d) > 0) begin
            drv_we[d] = ~we; drv_sel[d] = ~sel;
            drv_addr[d] = $urandom; drv_wdata[d] = $urandom;
         end
         while (cyc_n < ackc) begin @(posedge clk); #1; end
         rd_obs = mon_data[d];
         clear_bus(d);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] rd, a, v;
      int acks, n0, r;
      for (int d = 0; d < 2; d++) begin
         clear_bus(d);
         drv_addr[d] = 32'h0; drv_wdata[d] = 32'h0;
         last_rd[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack0", {31'd0, mon_ack[0]}, 32'd0);
      chk("rst_data3", mon_data[1], 32'h0);
      chk("rst_state0", 32'(st0), 32'(IDLE));
      chk("rst_state3", 32'(st3), 32'(IDLE));
      rst = 1'b0;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            access(d, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, 0, rd);

      // Directed, zero wait states.
      access(0, 1'b1, 4'hF, 32'h0001_0004, 32'hCAFE_F00D, 0, rd);
      access(0, 1'b0, 4'hF, 32'h0001_0004, 32'h0, 0, rd);
      chk("cafe_rd", rd, 32'hCAFE_F00D);
      access(0, 1'b1, 4'hF, 32'h0001_0008, 32'h1122_3344, 0, rd);
      access(0, 1'b1, 4'b1000, 32'h0001_0008, 32'hAA00_0000, 0, rd);
      access(0, 1'b1, 4'b0010, 32'h0001_000A, 32'h0000_BB00, 0, rd);
      access(0, 1'b0, 4'h0, 32'h0001_0008, 32'h0, 0, rd);
      chk("lane_rd", rd, 32'hAA22_BB44);
      chk("lane_model", mdl_mem[0][2], 32'hAA22_BB44);
      access(0, 1'b1, 4'h0, 32'h0001_0008, 32'hDEAD_BEEF, 0, rd);
      access(0, 1'b0, 4'hF, 32'h0001_0008, 32'h0, 0, rd);
      chk("sel0_rd", rd, 32'hAA22_BB44);

      // Out-of-window accesses; the full sweep re-reads every word.
      access(0, 1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, 0, rd);
      access(0, 1'b1, 4'hF, BASE - 32'd4, 32'hFFFF_FFFF, 0, rd);
      for (int i = 0; i < DEPTH; i++) access(0, 1'b0, 4'hF, BASE + 32'(i * 4), 32'h0, 0, rd);
      access(0, 1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'h0, 0, rd);
      chk("miss_hi_rd", rd, 32'h0);
      access(0, 1'b0, 4'hF, BASE + 32'(DEPTH * 4) - 32'd1, 32'h0, 0, rd);
      chk("last_word_rd", rd, mdl_mem[0][DEPTH-1]);

      // Held request: IDLE/ACK/RECOVER cadence gives acks at +1 and +4.
      @(posedge clk); #1;
      drv_cyc[0] = 1'b1; drv_stb[0] = 1'b1; drv_we[0] = 1'b1; drv_sel[0] = 4'hF;
      drv_addr[0] = 32'h0001_0010; drv_wdata[0] = 32'h0BB0_0110;
      n0 = cyc_n;
      mdl_mem[0][4] = 32'h0BB0_0110;
      mark(0, n0 + 1, 1'b0, 32'h0);
      mark(0, n0 + 4, 1'b0, 32'h0);
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (mon_ack[0]) acks++;
      end
      clear_bus(0);
      chk("held_acks", 32'(acks), 32'd2);
      @(posedge clk); #1;

      // Directed, three wait states, including an abort in the 2nd wait cycle.
      access(1, 1'b1, 4'hF, 32'h0001_0004, 32'hCAFE_F00D, 0, rd);
      access(1, 1'b0, 4'hF, 32'h0001_0004, 32'h0, 0, rd);
      chk("ws3_rd", rd, 32'hCAFE_F00D);
      v = mdl_mem[1][3];
      access(1, 1'b1, 4'hF, 32'h0001_000C, ~v, 2, rd);
      access(1, 1'b0, 4'hF, 32'h0001_000C, 32'h0, 0, rd);
      chk("abort_rd", rd, v);

      // Random traffic on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            else if (r == 1) a = BASE - 32'($urandom_range(1, 4) * 4);
            else if (r == 2) a = $urandom;
            else             a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            access(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                   (d == 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, rd);
         end
      end

      // Reset during the wait window of a write.
      access(1, 1'b1, 4'hF, 32'h0001_0014, 32'h5A5A_5A5A, 0, rd);
      access(1, 1'b0, 4'hF, 32'h0001_0014, 32'h0, 0, rd);
      v = mdl_mem[1][6];
      @(posedge clk); #1;
      drv_cyc[1] = 1'b1; drv_stb[1] = 1'b1; drv_we[1] = 1'b1; drv_sel[1] = 4'hF;
      drv_addr[1] = 32'h0001_0018; drv_wdata[1] = ~v;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      #1;
      chk("rst_mid_ack", {31'd0, mon_ack[1]}, 32'd0);
      chk("rst_mid_data", mon_data[1], 32'h0);
      clear_bus(1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_rel_state", 32'(st3), 32'(IDLE));
      access(1, 1'b0, 4'hF, 32'h0001_0018, 32'h0, 0, rd);
      chk("rst_lost_wr", rd, v);
      access(1, 1'b0, 4'hF, 32'h0001_0014, 32'h0, 0, rd);
      chk("rst_kept_wr", rd, 32'h5A5A_5A5A);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
